// File: rtl/rv32_rf_wb_arbiter.sv
// Register-file write-port arbiter between the ALU writeback and the load response path.
// Includes a 1-entry load skid buffer, a pending-load scoreboard and a starvation stall.
module rv32_rf_wb_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_wr_valid,
  input  logic [4:0]      alu_wr_rd,
  input  logic [XLEN-1:0] alu_wr_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_resp_valid,
  input  logic [4:0]      ld_resp_rd,
  input  logic [XLEN-1:0] ld_resp_data,
  output logic            ld_resp_ready,
  input  logic [4:0]      rs1_q,
  input  logic [4:0]      rs2_q,
  input  logic [4:0]      rd_q,
  output logic            issue_hazard,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            pipe_stall,
  output logic            err_waw
);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_BUF,
    SRC_RESP
  } wb_src_e;

  wb_src_e         src;
  logic            buf_full;
  logic [4:0]      buf_rd;
  logic [XLEN-1:0] buf_data;
  logic [3:0]      starve_cnt;
  logic [31:0]     pending;
  logic [31:0]     pending_nxt;
  logic            accept;
  logic            buf_load;
  logic            buf_written;
  logic            load_written;
  logic            cnt_inc;
  logic            starve_hit;
  logic            alu_waw;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  assign ld_resp_ready = ~buf_full;
  assign accept        = ld_resp_valid & ld_resp_ready;

  // A starved buffer outranks the ALU once the pipeline is frozen.
  always_comb begin
    src      = SRC_NONE;
    buf_load = 1'b0;
    if (pipe_stall && buf_full) begin
      src = SRC_BUF;
    end else if (alu_wr_valid) begin
      src      = SRC_ALU;
      buf_load = accept;
    end else if (buf_full) begin
      src = SRC_BUF;
    end else if (accept) begin
      src = SRC_RESP;
    end
  end

  always_comb begin
    win_rd   = 5'd0;
    win_data = '0;
    case (src)
      SRC_ALU: begin
        win_rd   = alu_wr_rd;
        win_data = alu_wr_data;
      end
      SRC_BUF: begin
        win_rd   = buf_rd;
        win_data = buf_data;
      end
      SRC_RESP: begin
        win_rd   = ld_resp_rd;
        win_data = ld_resp_data;
      end
      default: begin
        win_rd   = 5'd0;
        win_data = '0;
      end
    endcase
  end

  assign rf_we        = rst_n && (src != SRC_NONE) && (win_rd != 5'd0);
  assign rf_rd        = win_rd;
  assign rf_wdata     = win_data;
  assign buf_written  = (src == SRC_BUF);
  assign load_written = (src == SRC_BUF) || (src == SRC_RESP);
  assign alu_waw      = (src == SRC_ALU) && (alu_wr_rd != 5'd0) && pending[alu_wr_rd];

  assign cnt_inc    = buf_full && !buf_written;
  assign starve_hit = cnt_inc && (({1'b0, starve_cnt} + 5'd1) >= 5'(STARVE_MAX));

  // Clear first, then set, so a same-cycle issue to the same rd keeps it pending.
  always_comb begin
    pending_nxt = pending;
    if (load_written && (win_rd != 5'd0)) pending_nxt[win_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != 5'd0)) pending_nxt[ld_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign issue_hazard = ((rs1_q != 5'd0) && pending[rs1_q]) ||
                        ((rs2_q != 5'd0) && pending[rs2_q]) ||
                        ((rd_q  != 5'd0) && pending[rd_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full   <= 1'b0;
      buf_rd     <= 5'd0;
      buf_data   <= '0;
      starve_cnt <= 4'd0;
      pending    <= 32'd0;
      pipe_stall <= 1'b0;
      err_waw    <= 1'b0;
    end else begin
      if (buf_load) begin
        buf_full <= 1'b1;
        buf_rd   <= ld_resp_rd;
        buf_data <= ld_resp_data;
      end else if (buf_written) begin
        buf_full <= 1'b0;
      end
      if (!cnt_inc) starve_cnt <= 4'd0;
      else if (starve_cnt != 4'd15) starve_cnt <= starve_cnt + 4'd1;
      pending    <= pending_nxt;
      pipe_stall <= starve_hit;
      err_waw    <= err_waw | alu_waw;
    end
  end

endmodule

// File: doc/rv32_rf_wb_arbiter.md
Name: rv32_rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - the ALU writeback stage, which is single-cycle and cannot back-pressure;
  - the load/store unit response path, which has variable latency and uses a valid/ready handshake.
- Holds a 1-entry skid buffer for load data that loses arbitration.
- Keeps a 32-bit pending-load scoreboard used by issue logic for RAW/WAW stalls.
- Raises a registered pipeline stall when a buffered load is starved.
- Sits between EX/WB and the register file write port (write_reg/sel_d1/reg_d1).

Parameters:
- STARVE_MAX, 3, consecutive cycles a buffered load may lose before pipe_stall asserts (1..15).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_wr_valid  in  1  ALU writeback request
- alu_wr_rd  in  5  ALU destination
- alu_wr_data  in  XLEN  ALU result
- ld_issue  in  1  load issued this cycle (marks rd pending)
- ld_issue_rd  in  5  issued load destination
- ld_resp_valid  in  1  load data valid
- ld_resp_rd  in  5  load destination
- ld_resp_data  in  XLEN  load data
- ld_resp_ready  out  1  arbiter accepts load response
- rs1_q  in  5  issue-stage source 1
- rs2_q  in  5  issue-stage source 2
- rd_q  in  5  issue-stage destination
- issue_hazard  out  1  combinational: pending[rs1_q] | pending[rs2_q] | pending[rd_q] (index 0 always 0)
- rf_we  out  1  to RF write_reg
- rf_rd  out  5  to RF sel_d1
- rf_wdata  out  XLEN  to RF reg_d1
- pipe_stall  out  1  registered freeze request to pipeline
- err_waw  out  1  sticky: ALU wrote an rd with pending load

Behaviour:
- Reset (async) state:
  - buffer empty; pending = 0; starve counter = 0.
  - pipe_stall = 0; err_waw = 0.
  - Combinational outputs follow from this state: ld_resp_ready = 1; rf_we = 0 with no inputs.
- Load source for arbitration: the buffer if it is full, otherwise the incoming response.
  - Incoming response is accepted when ld_resp_valid & ld_resp_ready.
- ld_resp_ready = ~buf_full. It does not depend on alu_wr_valid.
- Write-port arbitration, combinational, same cycle:
  - pipe_stall=1 and buffer full: the buffer writes. ALU request is ignored this cycle; the pipeline is frozen and holds alu_wr_valid/rd/data unchanged, so the ALU writes next cycle.
  - Otherwise, alu_wr_valid=1: the ALU writes. An accepted incoming load goes into the buffer. A full buffer stays full.
  - Otherwise, a load source exists: the load writes. If the buffer wrote, it empties that cycle; new input cannot arrive because ready=0.
  - Otherwise, rf_we=0.
- rd=0 handling:
  - Any winner with rd=0 drives rf_we=0 but still counts as consumed.
  - A load to x0 never sets pending.
- Scoreboard:
  - Set pending[ld_issue_rd] on ld_issue.
  - Clear pending[rd] when that load's data is written to the RF. Buffering it does not clear.
  - Same rd set and cleared in the same cycle: set wins.
- Starve counter:
  - Increments each cycle the buffer is full and not written.
  - Clears when the buffer empties.
  - pipe_stall <= buf_full & (cnt+1 >= STARVE_MAX) & ~buffer_written_this_cycle.
  - pipe_stall clears the cycle after the buffer drains.
  - Counter saturates at 15.
- err_waw: set when the ALU writes an rd≠0 with pending[rd]=1. Cleared only by reset.
- Latency:
  - Load with no contention: written the same cycle it is accepted.
  - Loser: written no earlier than the next cycle.
  - Worst case: STARVE_MAX+1 cycles after acceptance.
- Reset mid-operation discards buffered data and all pending bits. No RF write occurs while rst_n=0.

Test Plan:
- Reset, then ld_resp_valid=1, rd=5, data=0xDEADBEEF, no ALU request -> same cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF, ld_resp_ready=1.
- ALU rd=3 0x11 and load rd=7 0x22 in the same cycle -> cycle 0 writes x3=0x11 and the buffer fills, ld_resp_ready=0; cycle 1 with no ALU request writes x7=0x22, ready=1.
- Buffer full, ALU writes every cycle (frozen held after stall), STARVE_MAX=3 -> pipe_stall rises after the 3rd losing cycle; the next cycle writes the buffered load while the held ALU write is skipped; the ALU writes the following cycle; pipe_stall drops.
- ld_issue rd=9, then rs1_q=9 -> issue_hazard=1; load response rd=9 written -> issue_hazard=0 the next cycle.
- Load response clears rd=4 in the same cycle ld_issue sets rd=4 -> pending[4] stays 1. ALU write to x4 while pending -> err_waw=1 sticky.
- Assert rst_n low with buffer full and pending bits set -> immediately ld_resp_ready=1, pipe_stall=0, issue_hazard=0, rf_we=0.
